coeff_seq_loader: RTL and testbench
===================================

Name: coeff_seq_loader

Overview:
Parametrised successor to the FIR coefficient loader. It sequences loading of NUM_COEFFS coefficients into the sample/coefficient datapath. Each load is handshaked against modwait and new_coefficient_set, and asserts load_coeff for a configurable pulse width. Compared with the fixed 4-coefficient loader, it adds reverse-order loading, a synchronous abort, a wait-state timeout and status outputs. It sits between the AHB-lite/APB slave register file and the FIR datapath controller.

Parameters:
NUM_COEFFS, 4, number of coefficients per set; legal range 2..16.
LOAD_CYCLES, 2, load_coeff high time per coefficient in cycles; legal range 1..8.
TIMEOUT_CYCLES, 255, maximum cycles spent in a wait state before error; 0 disables timeout.
IDX_W (localparam), $clog2(NUM_COEFFS), width of coefficient_num.

Ports:
clk  in  1  system clock, rising edge.
n_reset  in  1  asynchronous active-low reset.
new_coefficient_set  in  1  level; a new set (or the next coefficient) is pending.
modwait  in  1  datapath busy; no load may start while high.
reverse_order  in  1  when 1, load indices NUM_COEFFS-1 down to 0; sampled only at start.
abort  in  1  synchronous cancel of an in-progress set.
load_coeff  out  1  load strobe to datapath.
coefficient_num  out  IDX_W  index being loaded; registered.
clear  out  1  one-cycle pulse after the final coefficient.
busy  out  1  high in every state except IDLE.
set_done  out  1  one-cycle pulse coincident with clear.
timeout_err  out  1  sticky error flag; cleared on the next start.

Behaviour:
- Reset (async, n_reset=0): state=IDLE; coefficient_num=0; direction register=0; wait and load counters=0; timeout_err=0. All outputs 0.
- States: IDLE, WAIT_MOD, LOAD, WAIT_NEXT, CLEAR.
- IDLE, on new_coefficient_set=1: go to WAIT_MOD. coefficient_num <= reverse_order ? NUM_COEFFS-1 : 0. Latch reverse_order. Clear timeout_err.
- WAIT_MOD, trigger when modwait=0. WAIT_NEXT, trigger when new_coefficient_set=1 and modwait=0 in the same cycle.
  - The trigger cycle itself drives load_coeff=1 (Mealy). Next state is LOAD if LOAD_CYCLES>1, otherwise as at the end of LOAD (see below).
  - Otherwise the FSM holds its state.
- load_coeff is high for exactly LOAD_CYCLES consecutive cycles: the trigger cycle plus LOAD_CYCLES-1 cycles in LOAD.
- coefficient_num already holds the target index in the trigger cycle and stays stable across the whole pulse.
- End of LOAD (last high cycle):
  - If the index just loaded is the final one (NUM_COEFFS-1 forward, 0 reverse), go to CLEAR.
  - Otherwise go to WAIT_NEXT with coefficient_num incremented (forward) or decremented (reverse).
- new_coefficient_set and modwait are ignored during LOAD.
- CLEAR: clear=1 and set_done=1 for one cycle, load_coeff=0. coefficient_num <= 0. Next state is IDLE. new_coefficient_set is ignored in this cycle; a level still high in IDLE starts a new set.
- abort=1 in any non-IDLE state:
  - Highest priority below reset.
  - load_coeff forced to 0 that cycle.
  - Next state is IDLE, coefficient_num <= 0.
  - No clear, no set_done; timeout_err unchanged.
  - abort in IDLE has no effect, and suppresses a start in that same cycle.
- Timeout (TIMEOUT_CYCLES>0):
  - The wait counter resets to 0 on entry to WAIT_MOD/WAIT_NEXT and increments each cycle the trigger is not met.
  - When it reaches TIMEOUT_CYCLES: timeout_err <= 1, next state IDLE, coefficient_num <= 0, no clear.
  - A trigger in the same cycle as the timeout wins, and the load proceeds.
- busy=1 in WAIT_MOD, LOAD, WAIT_NEXT and CLEAR.
- Counters are saturating-free. Widths are sized from the parameters, with no wrap inside the legal ranges.

Test Plan:
1. Defaults, forward order. new_coefficient_set held high, modwait=0 → load_coeff high 2 cycles per index with coefficient_num 0,1,2,3 stable during each pulse. Then clear=set_done=1 for 1 cycle, coefficient_num=0, busy=0.
2. reverse_order=1 at start, toggled to 0 mid-set → indices loaded 3,2,1,0 (toggle ignored). clear after index 0.
3. modwait held high 10 cycles in WAIT_MOD, then low → no load_coeff while high. Load starts the exact cycle modwait drops, index 0, 2-cycle pulse.
4. abort asserted in the 1st LOAD cycle of index 2 → load_coeff 0 that cycle, IDLE next cycle, coefficient_num=0, no clear/set_done, busy=0.
5. TIMEOUT_CYCLES=5, new_coefficient_set dropped after index 1 → WAIT_NEXT expires after 5 cycles, timeout_err=1, IDLE, no clear. The next start clears timeout_err.
6. NUM_COEFFS=8, LOAD_CYCLES=1, n_reset pulsed low mid-LOAD of index 5 → all outputs 0 immediately. A restart loads 0..7 with 1-cycle pulses.

Source files
------------

// File: rtl/coeff_seq_loader.sv
// rtl/coeff_seq_loader.sv - FIR coefficient load sequencer
//
// Steps through NUM_COEFFS coefficient indices, forward or reverse, and
// raises load_coeff for LOAD_CYCLES cycles per index. Each load waits for
// the datapath (modwait low) and, after the first one, for
// new_coefficient_set as well. Supports a synchronous abort and an optional
// wait-state timeout.
//
// Ports:
//   clk                 in   rising-edge clock
//   n_reset             in   asynchronous active-low reset
//   new_coefficient_set in   a set / next coefficient is pending (level)
//   modwait             in   datapath busy, blocks the start of a load
//   reverse_order       in   load NUM_COEFFS-1 down to 0 (sampled at start)
//   abort               in   synchronous cancel of a set in progress
//   load_coeff          out  load strobe to the datapath
//   coefficient_num     out  registered index being loaded
//   clear               out  one-cycle pulse after the final coefficient
//   busy                out  high in every state except IDLE
//   set_done            out  one-cycle pulse coincident with clear
//   timeout_err         out  sticky wait-state timeout flag
module coeff_seq_loader #(
  parameter int NUM_COEFFS     = 4,
  parameter int LOAD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W         = $clog2(NUM_COEFFS)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             new_coefficient_set,
  input  logic             modwait,
  input  logic             reverse_order,
  input  logic             abort,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             clear,
  output logic             busy,
  output logic             set_done,
  output logic             timeout_err
);

  // Load counter holds the number of pulse cycles already spent (1..L-1).
  localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int WC_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_COEFFS - 1);
  localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(LOAD_CYCLES - 1);
  localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MOD  = 3'd1,
    LOAD      = 3'd2,
    WAIT_NEXT = 3'd3,
    CLEAR     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rev_q, rev_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [LC_W-1:0]  lcnt_q, lcnt_d;
  logic             terr_q, terr_d;

  logic             trig;
  logic             end_load;
  logic             load;
  logic             clr;
  logic [IDX_W-1:0] final_idx;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rev_d     = rev_q;
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    terr_d    = terr_q;
    trig      = 1'b0;
    end_load  = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    final_idx = rev_q ? '0 : LAST_IDX;

    case (state_q)
      IDLE: begin
        if (new_coefficient_set && !abort) begin
          state_d = WAIT_MOD;
          idx_d   = reverse_order ? LAST_IDX : '0;
          rev_d   = reverse_order;
          terr_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      WAIT_MOD, WAIT_NEXT: begin
        trig = (state_q == WAIT_MOD) ? !modwait : (new_coefficient_set && !modwait);
        if (trig) begin
          // Mealy: the trigger cycle is the first cycle of the pulse.
          load = 1'b1;
          if (LOAD_CYCLES > 1) begin
            state_d = LOAD;
            lcnt_d  = LC_W'(1);
          end else begin
            end_load = 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (wcnt_q == WAIT_MAX) begin
            terr_d  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      LOAD: begin
        load = 1'b1;
        if (lcnt_q == LOAD_LAST) begin
          end_load = 1'b1;
        end else begin
          lcnt_d = lcnt_q + LC_W'(1);
        end
      end
      CLEAR: begin
        clr     = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (end_load) begin
      if (idx_q == final_idx) begin
        state_d = CLEAR;
      end else begin
        state_d = WAIT_NEXT;
        idx_d   = rev_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
        wcnt_d  = '0;
      end
    end

    // Abort overrides everything, including a coincident timeout.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      terr_d  = terr_q;
      load    = 1'b0;
      clr     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rev_q   <= 1'b0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      terr_q  <= terr_d;
    end
  end

  assign load_coeff      = load;
  assign coefficient_num = idx_q;
  assign clear           = clr;
  assign set_done        = clr;
  assign busy            = (state_q != IDLE);
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_coeff_seq_loader.sv
// tb/tb_coeff_seq_loader.sv - scoreboard bench for coeff_seq_loader
//
// Two instances: dut0 (4 coeffs, 2-cycle pulse, timeout 12) and
// dut1 (8 coeffs, 1-cycle pulse, timeout 5). Stimulus pushes expected
// events (load pulse index/length, clear, timeout); a negedge monitor
// reconstructs events from the DUT outputs and pops/compares them.
module tb_coeff_seq_loader;

  logic       clk;
  logic       n_reset;
  logic [1:0] nset, mw, rv, ab;
  logic [1:0] lc, clr, busy, sd, te;
  logic [1:0] cn0;
  logic [2:0] cn1;
  logic [3:0] cn [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  coeff_seq_loader #(.NUM_COEFFS(4), .LOAD_CYCLES(2), .TIMEOUT_CYCLES(12)) dut0 (
    .clk(clk), .n_reset(n_reset), .new_coefficient_set(nset[0]), .modwait(mw[0]),
    .reverse_order(rv[0]), .abort(ab[0]), .load_coeff(lc[0]), .coefficient_num(cn0),
    .clear(clr[0]), .busy(busy[0]), .set_done(sd[0]), .timeout_err(te[0]));

  coeff_seq_loader #(.NUM_COEFFS(8), .LOAD_CYCLES(1), .TIMEOUT_CYCLES(5)) dut1 (
    .clk(clk), .n_reset(n_reset), .new_coefficient_set(nset[1]), .modwait(mw[1]),
    .reverse_order(rv[1]), .abort(ab[1]), .load_coeff(lc[1]), .coefficient_num(cn1),
    .clear(clr[1]), .busy(busy[1]), .set_done(sd[1]), .timeout_err(te[1]));

  assign cn[0] = {2'b00, cn0};
  assign cn[1] = {1'b0, cn1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nc_of(input int g);
    return (g != 0) ? 8 : 4;
  endfunction
  function automatic int lc_of(input int g);
    return (g != 0) ? 1 : 2;
  endfunction
  function automatic int to_of(input int g);
    return (g != 0) ? 5 : 12;
  endfunction

  // Event word: kind (1 load, 2 clear, 3 timeout), index, pulse length.
  function automatic logic [31:0] ev(input int kind, input int idx, input int len);
    return 32'(kind * 65536 + idx * 256 + len);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [31:0] e);
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic got(input int g, input logic [31:0] act);
    logic [31:0] e;
    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got 0x%0h expected none", g, act);
    end else begin
      e = (g == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("event_dut%0d", g), act, e);
    end
  endtask

  // Monitor: a pulse is a run of load_coeff with a constant index.
  initial begin
    bit       in_p [2];
    int       plen [2];
    int       pidx [2];
    bit       te_p [2];
    for (int g = 0; g < 2; g++) begin
      in_p[g] = 0; plen[g] = 0; pidx[g] = 0; te_p[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!n_reset) begin
          in_p[g] = 0;
          te_p[g] = 0;
        end else begin
          if (in_p[g] && (!lc[g] || int'(cn[g]) != pidx[g])) begin
            got(g, ev(1, pidx[g], plen[g]));
            in_p[g] = 0;
          end
          if (lc[g]) begin
            if (in_p[g]) plen[g]++;
            else begin
              in_p[g] = 1; pidx[g] = int'(cn[g]); plen[g] = 1;
            end
          end
          if (clr[g] || sd[g]) chk($sformatf("set_done_eq_clear_dut%0d", g), 32'(sd[g]), 32'(clr[g]));
          if (clr[g]) got(g, ev(2, 0, 0));
          if (te[g] && !te_p[g]) got(g, ev(3, 0, 0));
          te_p[g] = te[g];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in a wait-state cycle; issues one coefficient load.
  // ab_p: pulse cycle in which abort is raised (0 = trigger cycle, -1 none).
  task automatic load_one(input int g, input int idx, input int h, input int ab_p, output bit aborted);
    int L;
    L = lc_of(g);
    aborted = 0;
    nset[g] = 1'b1;
    mw[g]   = 1'b1;
    repeat (h) cyc();
    mw[g] = 1'b0;
    if (ab_p == 0) begin
      ab[g] = 1'b1;
      #1 chk("abort_in_trigger_no_load", 32'(lc[g]), 32'd0);
      cyc();
      ab[g] = 1'b0; nset[g] = 1'b0;
      aborted = 1;
      return;
    end
    #1 chk("trigger_load", 32'(lc[g]), 32'd1);
    chk("trigger_idx", 32'(cn[g]), 32'(idx));
    push(g, ev(1, idx, (ab_p > 0 && ab_p < L) ? ab_p : L));
    for (int j = 1; j < L; j++) begin
      cyc();
      mw[g]   = 1'($urandom_range(0, 1));
      nset[g] = 1'($urandom_range(0, 1));
      if (j == ab_p) begin
        ab[g] = 1'b1;
        #1 chk("abort_in_load_no_load", 32'(lc[g]), 32'd0);
        cyc();
        ab[g] = 1'b0; nset[g] = 1'b0;
        aborted = 1;
        return;
      end
    end
    cyc();
    nset[g] = 1'b1;
    mw[g]   = 1'b1;
  endtask

  task automatic run_set(input int g, input bit r, input int ab_k, input int ab_p,
                         input int to_k, input int h0);
    int N, T, idx, h, n;
    bit a;
    N = nc_of(g);
    T = to_of(g);
    nset[g] = 1'b1; rv[g] = r; mw[g] = 1'b1;
    cyc();
    chk("start_busy", 32'(busy[g]), 32'd1);
    chk("start_clears_timeout", 32'(te[g]), 32'd0);
    rv[g] = ~r;
    for (int k = 0; k < N; k++) begin
      idx = r ? (N - 1 - k) : k;
      if (k == 0 && h0 >= 0) h = h0;
      else h = ($urandom_range(0, 3) == 0) ? T : int'($urandom_range(0, 3));
      load_one(g, idx, h, (k == ab_k) ? ab_p : -1, a);
      if (a) begin
        chk("abort_idle", 32'(busy[g]), 32'd0);
        chk("abort_idx_zero", 32'(cn[g]), 32'd0);
        return;
      end
      if (k == to_k) begin
        nset[g] = 1'b0;
        push(g, ev(3, 0, 0));
        n = 0;
        while (busy[g] && n < T + 10) begin
          cyc();
          n++;
        end
        chk("timeout_wait_cycles", 32'(n), 32'(T + 1));
        chk("timeout_err_set", 32'(te[g]), 32'd1);
        chk("timeout_idx_zero", 32'(cn[g]), 32'd0);
        return;
      end
    end
    push(g, ev(2, 0, 0));
    chk("clear_busy", 32'(busy[g]), 32'd1);
    nset[g] = 1'b0;
    cyc();
    chk("after_clear_idle", 32'(busy[g]), 32'd0);
    chk("after_clear_idx", 32'(cn[g]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int g, sel, ab_k, ab_p, to_k;
    n_reset = 1'b0;
    nset = '0; mw = '0; rv = '0; ab = '0;
    repeat (3) cyc();
    for (int i = 0; i < 2; i++) begin
      chk("reset_load", 32'(lc[i]), 32'd0);
      chk("reset_idx", 32'(cn[i]), 32'd0);
      chk("reset_clear", 32'(clr[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_set_done", 32'(sd[i]), 32'd0);
      chk("reset_timeout", 32'(te[i]), 32'd0);
    end
    n_reset = 1'b1;
    cyc();

    run_set(0, 1'b0, -1, -1, -1, 0);    // forward, modwait low
    run_set(0, 1'b1, -1, -1, -1, 0);    // reverse with mid-set toggle
    run_set(0, 1'b0, -1, -1, -1, 10);   // modwait held 10 cycles
    run_set(0, 1'b0, 2, 1, -1, -1);     // abort in first LOAD cycle of index 2

    // abort in IDLE suppresses a start
    ab[0] = 1'b1; nset[0] = 1'b1;
    cyc();
    chk("idle_abort_no_start", 32'(busy[0]), 32'd0);
    ab[0] = 1'b0; nset[0] = 1'b0;
    cyc();

    run_set(1, 1'b0, -1, -1, 1, -1);    // timeout after index 1
    run_set(1, 1'b0, -1, -1, -1, 5);    // restart clears error; trigger at the timeout cycle

    // async reset in the load cycle of index 5
    nset[1] = 1'b1; rv[1] = 1'b0; mw[1] = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) load_one(1, k, 1, -1, a);
    cyc();
    mw[1] = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    chk("async_reset_load", 32'(lc[1]), 32'd0);
    chk("async_reset_idx", 32'(cn[1]), 32'd0);
    chk("async_reset_busy", 32'(busy[1]), 32'd0);
    nset[1] = 1'b0; mw[1] = 1'b1;
    cyc();
    n_reset = 1'b1;
    cyc();
    run_set(1, 1'b0, -1, -1, -1, 1);

    for (int i = 0; i < 14; i++) begin
      g    = int'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 2));
      ab_k = -1; ab_p = -1; to_k = -1;
      if (sel == 1) begin
        ab_k = int'($urandom_range(0, nc_of(g) - 1));
        ab_p = int'($urandom_range(0, lc_of(g) - 1));
      end else if (sel == 2) begin
        to_k = int'($urandom_range(0, nc_of(g) - 2));
      end
      run_set(g, 1'($urandom_range(0, 1)), ab_k, ab_p, to_k, -1);
      cyc();
    end

    repeat (3) cyc();
    chk("scoreboard_empty_dut0", 32'(q0.size()), 32'd0);
    chk("scoreboard_empty_dut1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
